// File: rtl/bin2dec_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3 over W clocks behind a
// start/done handshake, with sign flag and significant-digit count.
module bin2dec_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     is_signed,
  input  logic [W-1:0]             din,
  output logic                     busy,
  output logic                     done,
  output logic                     neg,
  output logic [4*D-1:0]           bcd,
  output logic [$clog2(D+1)-1:0]   ndigits
);

  localparam int unsigned NW = $clog2(D + 1);
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]     state;
  logic [W-1:0]   mag;
  logic [4*D-1:0] work;
  logic [CW-1:0]  cnt;
  logic           neg_r;

  logic [W-1:0]   din_mag;
  logic           din_neg;
  logic [4*D-1:0] work_adj;
  logic [4*D-1:0] work_next;
  logic [W-1:0]   mag_next;
  logic [NW-1:0]  nd_next;
  logic           last_step;

  // Two's-complement negate as W-bit unsigned: the most negative input maps
  // to 2^(W-1) without overflow.
  assign din_neg = is_signed & din[W-1];
  assign din_mag = din_neg ? (~din + W'(1)) : din;

  always_comb begin
    work_adj = work;
    for (int unsigned d = 0; d < D; d++) begin
      if (work[4*d +: 4] >= 4'd5) begin
        work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
      end
    end
  end

  assign work_next = {work_adj[4*D-2:0], mag[W-1]};
  assign mag_next  = {mag[W-2:0], 1'b0};
  assign last_step = (cnt == CW'(W - 1));

  // Digit count from the final work value; an all-zero result reports 1.
  always_comb begin
    nd_next = NW'(1);
    for (int unsigned d = 1; d < D; d++) begin
      if (work_next[4*d +: 4] != 4'd0) begin
        nd_next = NW'(d + 1);
      end
    end
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mag     <= '0;
      work    <= '0;
      cnt     <= '0;
      neg_r   <= 1'b0;
      done    <= 1'b0;
      neg     <= 1'b0;
      bcd     <= '0;
      ndigits <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag   <= din_mag;
            neg_r <= din_neg;
            work  <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= work_next;
          mag  <= mag_next;
          cnt  <= cnt + CW'(1);
          if (last_step) begin
            bcd     <= work_next;
            neg     <= neg_r;
            ndigits <= nd_next;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2dec_seq.sv
// Directed and exhaustive checks of bin2dec_seq against hand-computed and
// integer-arithmetic decimal values.
module tb_bin2dec_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [7:0]  din;
  logic        busy;
  logic        done;
  logic        neg;
  logic [11:0] bcd;
  logic [1:0]  ndigits;

  int n_chk  = 0;
  int n_fail = 0;

  bin2dec_seq #(.W(8), .D(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .neg       (neg),
    .bcd       (bcd),
    .ndigits   (ndigits)
  );

  always #5 clk = ~clk;

  // Issue one start and wait (bounded) for done; lat is edges from acceptance
  // to done (-1 on timeout), bcnt counts cycles with busy high before done.
  task automatic run_conv(input logic s, input logic [7:0] v,
                          output logic [11:0] b, output logic n,
                          output logic [1:0] nd, output int lat, output int bcnt);
    @(negedge clk);
    is_signed = s; din = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    b = bcd; n = neg; nd = ndigits;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; din = '0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_chk++; if (neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg got %0b want 0", neg); end
    n_chk++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got %h want 000", bcd); end
    n_chk++; if (ndigits !== 2'd0) begin n_fail++; $display("FAIL reset_ndigits got %0d want 0", ndigits); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_15;
    logic [11:0] b; logic n; logic [1:0] nd; int lat, bcnt;
    run_conv(1'b0, 8'd15, b, n, nd, lat, bcnt);
    n_chk++; if (lat != 8) begin n_fail++; $display("FAIL u15_latency got %0d want 8", lat); end
    n_chk++; if (bcnt != 8) begin n_fail++; $display("FAIL u15_busy_cycles got %0d want 8", bcnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL u15_busy_in_done got %0b want 0", busy); end
    n_chk++; if (b !== 12'h015) begin n_fail++; $display("FAIL u15_bcd got %h want 015", b); end
    n_chk++; if (n !== 1'b0) begin n_fail++; $display("FAIL u15_neg got %0b want 0", n); end
    n_chk++; if (nd !== 2'd2) begin n_fail++; $display("FAIL u15_ndigits got %0d want 2", nd); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL u15_done_width got %0b want 0", done); end
    n_chk++; if (bcd !== 12'h015) begin n_fail++; $display("FAIL u15_bcd_hold got %h want 015", bcd); end
  endtask

  task automatic test_signed;
    logic [11:0] b; logic n; logic [1:0] nd; int lat, bcnt;
    run_conv(1'b1, 8'hF1, b, n, nd, lat, bcnt);
    n_chk++; if (b !== 12'h015) begin n_fail++; $display("FAIL s_f1_bcd got %h want 015", b); end
    n_chk++; if (n !== 1'b1) begin n_fail++; $display("FAIL s_f1_neg got %0b want 1", n); end
    n_chk++; if (nd !== 2'd2) begin n_fail++; $display("FAIL s_f1_ndigits got %0d want 2", nd); end
    run_conv(1'b0, 8'hF1, b, n, nd, lat, bcnt);
    n_chk++; if (b !== 12'h241) begin n_fail++; $display("FAIL u_f1_bcd got %h want 241", b); end
    n_chk++; if (n !== 1'b0) begin n_fail++; $display("FAIL u_f1_neg got %0b want 0", n); end
    n_chk++; if (nd !== 2'd3) begin n_fail++; $display("FAIL u_f1_ndigits got %0d want 3", nd); end
  endtask

  task automatic test_boundaries;
    logic [11:0] b; logic n; logic [1:0] nd; int lat, bcnt;
    run_conv(1'b1, 8'h80, b, n, nd, lat, bcnt);
    n_chk++; if (b !== 12'h128) begin n_fail++; $display("FAIL s_80_bcd got %h want 128", b); end
    n_chk++; if (n !== 1'b1) begin n_fail++; $display("FAIL s_80_neg got %0b want 1", n); end
    n_chk++; if (nd !== 2'd3) begin n_fail++; $display("FAIL s_80_ndigits got %0d want 3", nd); end
    run_conv(1'b0, 8'hFF, b, n, nd, lat, bcnt);
    n_chk++; if (b !== 12'h255) begin n_fail++; $display("FAIL u_ff_bcd got %h want 255", b); end
    n_chk++; if (nd !== 2'd3) begin n_fail++; $display("FAIL u_ff_ndigits got %0d want 3", nd); end
    run_conv(1'b1, 8'h00, b, n, nd, lat, bcnt);
    n_chk++; if (b !== 12'h000) begin n_fail++; $display("FAIL s_00_bcd got %h want 000", b); end
    n_chk++; if (n !== 1'b0) begin n_fail++; $display("FAIL s_00_neg got %0b want 0", n); end
    n_chk++; if (nd !== 2'd1) begin n_fail++; $display("FAIL s_00_ndigits got %0d want 1", nd); end
  endtask

  // Ends on the negedge where done is high, leaving the done cycle to the next task.
  task automatic test_ignore_start;
    int lat, ndone;
    @(negedge clk);
    is_signed = 1'b0; din = 8'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0; ndone = 0;
    while (!done && lat < 20) begin
      start = (lat == 3 || lat == 5);
      is_signed = start;
      din = start ? 8'h99 : 8'd15;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_chk++; if (lat != 8) begin n_fail++; $display("FAIL ign_latency got %0d want 8", lat); end
    n_chk++; if (bcd !== 12'h015) begin n_fail++; $display("FAIL ign_bcd got %h want 015", bcd); end
    n_chk++; if (neg !== 1'b0) begin n_fail++; $display("FAIL ign_neg got %0b want 0", neg); end
  endtask

  task automatic test_back_to_back;
    int lat;
    is_signed = 1'b0; din = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %0b want 1", busy); end
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_chk++; if (lat != 8) begin n_fail++; $display("FAIL b2b_latency got %0d want 8", lat); end
    n_chk++; if (bcd !== 12'h007) begin n_fail++; $display("FAIL b2b_bcd got %h want 007", bcd); end
    n_chk++; if (ndigits !== 2'd1) begin n_fail++; $display("FAIL b2b_ndigits got %0d want 1", ndigits); end
  endtask

  task automatic test_reset_abort;
    logic [11:0] b; logic n; logic [1:0] nd; int lat, bcnt, ndone;
    @(negedge clk);
    is_signed = 1'b0; din = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_pre got %0b want 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %0b want 0", done); end
    n_chk++; if (neg !== 1'b0) begin n_fail++; $display("FAIL abort_neg got %0b want 0", neg); end
    n_chk++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL abort_bcd got %h want 000", bcd); end
    n_chk++; if (ndigits !== 2'd0) begin n_fail++; $display("FAIL abort_ndigits got %0d want 0", ndigits); end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_chk++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    run_conv(1'b0, 8'd200, b, n, nd, lat, bcnt);
    n_chk++; if (lat != 8) begin n_fail++; $display("FAIL abort_rerun_latency got %0d want 8", lat); end
    n_chk++; if (b !== 12'h200) begin n_fail++; $display("FAIL abort_rerun_bcd got %h want 200", b); end
    n_chk++; if (nd !== 2'd3) begin n_fail++; $display("FAIL abort_rerun_ndigits got %0d want 3", nd); end
  endtask

  task automatic test_exhaustive;
    logic [8:0]  iv, nv;
    logic [11:0] e_bcd;
    logic        e_neg;
    logic [1:0]  e_nd;
    int          mag, lat;
    @(negedge clk);
    is_signed = 1'b0; din = 8'h00; start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      iv = 9'(i);
      @(negedge clk);
      start = 1'b0; lat = 0;
      while (!done && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      e_neg = iv[8] && iv[7];
      mag   = e_neg ? (256 - int'(iv[7:0])) : int'(iv[7:0]);
      e_bcd = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
      e_nd  = (mag >= 100) ? 2'd3 : (mag >= 10) ? 2'd2 : 2'd1;
      n_chk++; if (lat != 8) begin n_fail++; $display("FAIL ex_latency s=%0b din=%h got %0d want 8", iv[8], iv[7:0], lat); end
      n_chk++; if (bcd !== e_bcd) begin n_fail++; $display("FAIL ex_bcd s=%0b din=%h got %h want %h", iv[8], iv[7:0], bcd, e_bcd); end
      n_chk++; if (neg !== e_neg) begin n_fail++; $display("FAIL ex_neg s=%0b din=%h got %0b want %0b", iv[8], iv[7:0], neg, e_neg); end
      n_chk++; if (ndigits !== e_nd) begin n_fail++; $display("FAIL ex_ndigits s=%0b din=%h got %0d want %0d", iv[8], iv[7:0], ndigits, e_nd); end
      if (i < 511) begin
        nv = 9'(i + 1);
        is_signed = nv[8]; din = nv[7:0]; start = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_15();
    test_signed();
    test_boundaries();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
